// File: rtl/ebpc_enc_sequencer.sv
// Frames a counted word stream into BLOCK_SIZE blocks for the EBPC encoder,
// zero-pads the final partial block, tags the last beat with flush and pulses done.
module ebpc_enc_sequencer #(
  parameter int DATA_W        = 8,
  parameter int BLOCK_SIZE    = 8,
  parameter int LOG_MAX_WORDS = 24
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [LOG_MAX_WORDS-1:0] num_words_i,
  input  logic                     num_words_valid_i,
  output logic                     num_words_ready_o,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     vld_i,
  output logic                     rdy_o,
  output logic [DATA_W-1:0]        data_o,
  output logic                     vld_o,
  input  logic                     rdy_i,
  output logic                     block_last_o,
  output logic                     pad_o,
  output logic                     flush_o,
  output logic                     idle_o,
  output logic                     done_o
);

  localparam int IDX_W = $clog2(BLOCK_SIZE);
  localparam logic [IDX_W-1:0]         IDX_LAST = IDX_W'(BLOCK_SIZE - 1);
  localparam logic [IDX_W-1:0]         IDX_ONE  = IDX_W'(1);
  localparam logic [LOG_MAX_WORDS-1:0] REM_ONE  = LOG_MAX_WORDS'(1);

  typedef enum logic [2:0] {IDLE, RUN, PAD, DRAIN, DONE} state_t;

  state_t                   state;
  logic [LOG_MAX_WORDS-1:0] rem;
  logic [IDX_W-1:0]         idx;
  logic                     can_load;
  logic                     in_xfer;
  logic                     blk_end;

  assign can_load          = !vld_o || rdy_i;
  assign rdy_o             = (state == RUN) && can_load;
  assign in_xfer           = vld_i && rdy_o;
  assign blk_end           = (idx == IDX_LAST);
  assign num_words_ready_o = (state == IDLE);
  assign idle_o            = (state == IDLE);
  assign done_o            = (state == DONE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      rem          <= '0;
      idx          <= '0;
      data_o       <= '0;
      vld_o        <= 1'b0;
      block_last_o <= 1'b0;
      pad_o        <= 1'b0;
      flush_o      <= 1'b0;
    end else begin
      // Drained beat empties the register unless a new load below refills it.
      if (vld_o && rdy_i) vld_o <= 1'b0;

      case (state)
        IDLE: begin
          if (num_words_valid_i) begin
            if (num_words_i != '0) begin
              rem   <= num_words_i;
              idx   <= '0;
              state <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end

        RUN: begin
          if (in_xfer) begin
            data_o       <= data_i;
            vld_o        <= 1'b1;
            pad_o        <= 1'b0;
            block_last_o <= blk_end;
            rem          <= rem - REM_ONE;
            idx          <= idx + IDX_ONE;
            if (rem == REM_ONE) begin
              flush_o <= blk_end;
              state   <= blk_end ? DRAIN : PAD;
            end else begin
              flush_o <= 1'b0;
            end
          end
        end

        PAD: begin
          // rem is already zero here; only the block position moves.
          if (can_load) begin
            data_o       <= '0;
            vld_o        <= 1'b1;
            pad_o        <= 1'b1;
            block_last_o <= blk_end;
            flush_o      <= blk_end;
            idx          <= idx + IDX_ONE;
            if (blk_end) state <= DRAIN;
          end
        end

        DRAIN: begin
          if (vld_o && rdy_i) state <= DONE;
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ebpc_enc_sequencer.sv
// Directed + randomized bench for ebpc_enc_sequencer against a transmission-level model.
module tb_ebpc_enc_sequencer;

  localparam int DW = 8;
  localparam int BS = 8;
  localparam int LW = 24;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [LW-1:0] num_words = '0;
  logic          num_words_valid = 1'b0;
  logic          num_words_ready_o;
  logic [DW-1:0] data_i = '0;
  logic          vld_i = 1'b0;
  logic          rdy_o;
  logic [DW-1:0] data_o;
  logic          vld_o;
  logic          rdy_i = 1'b0;
  logic          block_last_o, pad_o, flush_o, idle_o, done_o;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  logic [DW+2:0] beat_q[$];
  int done_cnt, done_cyc, flush_cyc, first_cyc, last_cyc, cfg_cyc;
  bit hold_cfg = 1'b0;

  logic [DW+3:0] prev_out;
  logic [DW+3:0] cur_out;
  bit            hold = 1'b0;

  ebpc_enc_sequencer #(.DATA_W(DW), .BLOCK_SIZE(BS), .LOG_MAX_WORDS(LW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .num_words_i(num_words), .num_words_valid_i(num_words_valid),
    .num_words_ready_o(num_words_ready_o),
    .data_i(data_i), .vld_i(vld_i), .rdy_o(rdy_o),
    .data_o(data_o), .vld_o(vld_o), .rdy_i(rdy_i),
    .block_last_o(block_last_o), .pad_o(pad_o), .flush_o(flush_o),
    .idle_o(idle_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Output monitor: stall stability, beat capture, done timing.
  always @(negedge clk) begin
    if (!rst_ni) begin
      hold = 1'b0;
    end else begin
      cur_out = {vld_o, data_o, block_last_o, pad_o, flush_o};
      if (hold) begin
        nchk++;
        assert (cur_out === prev_out) else begin
          nfail++;
          $error("FAIL stall_stable: observed %0h expected %0h", cur_out, prev_out);
        end
      end
      hold     = vld_o && !rdy_i;
      prev_out = cur_out;
      if (vld_o && rdy_i) begin
        if (beat_q.size() == 0) first_cyc = cyc;
        last_cyc = cyc;
        if (flush_o) flush_cyc = cyc;
        beat_q.push_back({data_o, block_last_o, pad_o, flush_o});
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_vld_o", vld_o, 0);
    check("rst_data_o", data_o, 0);
    check("rst_block_last", block_last_o, 0);
    check("rst_pad", pad_o, 0);
    check("rst_flush", flush_o, 0);
    check("rst_done", done_o, 0);
    check("rst_rdy_o", rdy_o, 0);
    check("rst_cfg_ready", num_words_ready_o, 1);
    check("rst_idle", idle_o, 1);
  endtask

  task automatic do_cfg(input int n);
    @(posedge clk); #1;
    num_words = LW'(n);
    num_words_valid = 1'b1;
    @(negedge clk);
    check("cfg_ready", num_words_ready_o, 1);
    cfg_cyc = cyc;
    @(posedge clk); #1;
    num_words_valid = hold_cfg;
  endtask

  // Called #1 after the edge on which the config transfer happened.
  task automatic run_body(input int n, input int vp, input int rp, input int base);
    logic [DW-1:0] words[$];
    logic [DW+2:0] exp_beat;
    int total, sent, guard;
    bit xfer, first;
    for (int i = 0; i < n; i++)
      words.push_back(base >= 0 ? DW'(base + i) : DW'($urandom));
    total = ((n + BS - 1) / BS) * BS;
    beat_q.delete();
    done_cnt = 0; done_cyc = -1; flush_cyc = -1;
    sent = 0; guard = 0; xfer = 1'b0; first = 1'b1;
    while (done_cnt == 0 && guard < 3000) begin
      if (xfer) sent++;
      vld_i  = ($urandom_range(99) < vp);
      data_i = (sent < n) ? words[sent] : DW'(8'hEE);
      rdy_i  = ($urandom_range(99) < rp);
      @(negedge clk);
      if (first && n > 0) check("first_rdy", rdy_o, 1);
      first = 1'b0;
      if (sent >= n) check("rdy_low_after_last", rdy_o, 0);
      if (n == 0) check("empty_no_vld", vld_o, 0);
      check("cfg_not_ready_busy", num_words_ready_o, 0);
      xfer = vld_i && rdy_o && (sent < n);
      @(posedge clk); #1;
      guard++;
    end
    vld_i = 1'b0;
    check("done_timeout", (guard < 3000), 1);
    @(negedge clk);
    check("idle_after_done", idle_o, 1);
    check("cfg_ready_after_done", num_words_ready_o, 1);
    check("done_pulses", done_cnt, 1);
    if (n > 0) check("done_after_flush", done_cyc, flush_cyc + 1);
    else       check("done_after_cfg", done_cyc, cfg_cyc + 1);
    check("beat_count", beat_q.size(), total);
    for (int i = 0; i < total && i < beat_q.size(); i++) begin
      exp_beat = {(i < n) ? words[i] : DW'(0), (i % BS) == BS - 1, i >= n, i == total - 1};
      check($sformatf("beat%0d", i), beat_q[i], exp_beat);
    end
    if (vp == 100 && rp == 100 && n > 0)
      check("full_rate", last_cyc - first_cyc, total - 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    rst_ni = 1'b1;
    @(negedge clk);
    check_reset_vals();
    rdy_i = 1'b1;

    // Exact multiple, partial block, empty transmission.
    do_cfg(16); run_body(16, 100, 100, 1);
    do_cfg(3);  run_body(3, 100, 100, 8'hA1);
    do_cfg(0);  run_body(0, 100, 100, 0);

    // Random backpressure and random lengths.
    do_cfg(10); run_body(10, 50, 50, -1);
    for (int k = 0; k < 4; k++) begin
      int n;
      n = $urandom_range(1, 20);
      do_cfg(n);
      run_body(n, $urandom_range(30, 100), $urandom_range(30, 100), -1);
    end

    // Reset after 5 of 8 words.
    do_cfg(8);
    vld_i = 1'b1; rdy_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i = DW'(8'h30 + i);
      @(posedge clk); #1;
    end
    rst_ni = 1'b0; vld_i = 1'b0;
    @(negedge clk);
    check_reset_vals();
    rst_ni = 1'b1;
    do_cfg(8); run_body(8, 100, 100, 8'h40);

    // Config valid held through a run; second config lands in the first IDLE cycle.
    hold_cfg = 1'b1;
    do_cfg(8); run_body(8, 100, 100, 8'h60);
    @(posedge clk); #1;
    hold_cfg = 1'b0;
    num_words_valid = 1'b0;
    run_body(8, 100, 100, 8'h70);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
